// File: rtl/inst_mem_loader_pkg.sv
// Shared core definitions for the instruction memory loader:
// datapath width, loader stream marker, fetch filler word and FSM state type.
package inst_mem_loader_pkg;

    localparam int unsigned cXLEN = 32;

    // Loader stream terminator; never written into instruction memory.
    localparam logic [cXLEN-1:0] cEndMarker = 32'hdeabbeaf;

    // addi x0, x0, 0 -- returned for out-of-range or misaligned fetches.
    localparam logic [cXLEN-1:0] cNop = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    // True when a byte address points at the start of a 32-bit word.
    function automatic logic is_word_aligned(input logic [cXLEN-1:0] byte_addr);
        return (byte_addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Loader-stream and fetch-port bundle of the instruction memory loader.
// master: the side driving the loader stream and fetch requests.
// slave:  the instruction memory loader itself.
interface inst_mem_loader_if
    import inst_mem_loader_pkg::*;
#(
    parameter int AW = 10
);

    logic             wrEn;
    logic [cXLEN-1:0] wrData;
    logic             fetchEn;
    logic [cXLEN-1:0] fetchAddr;
    logic [cXLEN-1:0] fetchData;
    logic             fetchValid;
    logic             fetchErr;
    logic             loadDone;
    logic [AW:0]      instCount;
    logic             overflow;

    modport master (
        output wrEn, wrData, fetchEn, fetchAddr,
        input  fetchData, fetchValid, fetchErr, loadDone, instCount, overflow
    );

    modport slave (
        input  wrEn, wrData, fetchEn, fetchAddr,
        output fetchData, fetchValid, fetchErr, loadDone, instCount, overflow
    );

endinterface

// File: rtl/inst_mem_loader_ram.sv
// Synchronous simple dual-port RAM: one write port, one read port with
// one-cycle read latency. Contents are not reset.
module inst_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port; rdata keeps its value when re=0.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: captures an instruction stream into RAM
// (IDLE -> LOAD), then serves word fetches from the core (RUN) with
// one-cycle latency, bounds and alignment checking.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_mem_loader_if.slave     bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_RUN  = ST_RUN;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      inst_count;
    logic             overflow_q;

    logic             loading;
    logic             is_marker;
    logic             full;
    logic             do_write;
    logic             drop_write;

    logic             fetch_req;
    logic [AW-1:0]    fetch_idx;
    logic             misaligned;
    logic             out_of_range;

    logic             fetch_valid_q;
    logic             fetch_err_q;
    logic             fetch_nop_q;
    logic [cXLEN-1:0] data_hold;
    logic [cXLEN-1:0] ram_rdata;
    logic [cXLEN-1:0] fetch_data;

    // Address bits above the word index are deliberately ignored.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^bus.fetchAddr[cXLEN-1:AW+2];

    // Write-side decode.
    always_comb begin
        loading    = (state == S_IDLE) || (state == S_LOAD);
        is_marker  = (bus.wrData == cEndMarker);
        full       = (inst_count == FULL_COUNT);
        do_write   = loading && bus.wrEn && !is_marker && !full;
        drop_write = loading && bus.wrEn && !is_marker && full;
    end

    // Fetch-side decode; only RUN accepts fetch requests.
    always_comb begin
        fetch_req    = (state == S_RUN) && bus.fetchEn;
        fetch_idx    = bus.fetchAddr[AW+1:2];
        misaligned   = !is_word_aligned(bus.fetchAddr);
        out_of_range = ({1'b0, fetch_idx} >= inst_count);
    end

    // Next-state logic: RUN is terminal until reset.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (bus.wrEn) state_next = S_LOAD;
            S_LOAD: if (!bus.wrEn || is_marker) state_next = S_RUN;
            S_RUN:  state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    // State, write pointer, stored-word count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            inst_count <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_next;
            if (do_write) begin
                wr_ptr     <= wr_ptr + 1'b1;
                inst_count <= inst_count + 1'b1;
            end
            if (drop_write) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Fetch response tracking aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_nop_q   <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_req;
            fetch_err_q   <= fetch_req && misaligned;
            fetch_nop_q   <= fetch_req && (misaligned || out_of_range);
        end
    end

    // Holding register so fetchData keeps its last value between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_hold <= '0;
        end else if (fetch_valid_q) begin
            data_hold <= fetch_data;
        end
    end

    inst_ram #(
        .DEPTH (DEPTH),
        .WIDTH (cXLEN),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr),
        .wdata (bus.wrData),
        .re    (fetch_req),
        .raddr (fetch_idx),
        .rdata (ram_rdata)
    );

    // Output mux: RAM word, NOP filler, or the held previous result.
    always_comb begin
        if (fetch_valid_q) begin
            fetch_data = fetch_nop_q ? cNop : ram_rdata;
        end else begin
            fetch_data = data_hold;
        end
    end

    assign bus.fetchData  = fetch_data;
    assign bus.fetchValid = fetch_valid_q;
    assign bus.fetchErr   = fetch_err_q;
    assign bus.loadDone   = (state == S_RUN);
    assign bus.instCount  = inst_count;
    assign bus.overflow   = overflow_q;

endmodule
